sample_feeder: RTL and testbench
================================

SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter DATA_W, default 16: sample width in bits.
REQ-002 Parameter INIT_CYCLES, default 16383: clk cycles from reset release to the rst_proc pulse.
REQ-003 Parameter CNT_W, default 16: width of the drop counter.
REQ-004 clk  in  1  single clock for all logic; everything is sampled on the rising edge.
REQ-005 rst_geral_n  in  1  asynchronous, active-low reset.
REQ-006 restart  in  1  synchronous request to re-run the startup sequence.
REQ-007 adc_data  in  DATA_W  signed sample.
REQ-008 adc_valid  in  1  adc_data is valid this cycle.
REQ-009 fifo_afull  in  1  downstream FIFO can accept at most one more write.
REQ-010 data  out  DATA_W  signed sample written to the FIFO; registered.
REQ-011 wrreq  out  1  FIFO write strobe; one cycle per sample; registered.
REQ-012 rst_proc  out  1  one-cycle processor reset pulse; registered.
REQ-013 running  out  1  high while the state is RUN.
REQ-014 drop_cnt  out  CNT_W  count of discarded samples; saturates at all-ones.
REQ-015 overflow  out  1  sticky flag set on the first drop.

Function
REQ-016 The state machine SHALL have three states: WAIT_INIT, PULSE, RUN.
REQ-017 WAIT_INIT SHALL increment a cycle counter from 0; when the counter equals INIT_CYCLES, the next state SHALL be PULSE.
REQ-018 PULSE SHALL last exactly one cycle and SHALL register rst_proc=1, so rst_proc is high during the cycle after PULSE.
REQ-019 After PULSE the next state SHALL be RUN, where the block stays until restart or reset.
REQ-020 While not in RUN, adc_valid SHALL be ignored: no write, no hold, no drop count.
REQ-021 In RUN the block SHALL hold a one-entry register (hold_data, hold_valid).
REQ-022 In RUN, if hold_valid=1 and fifo_afull=0, the block SHALL write hold_data.
- If adc_valid=1 in that cycle, adc_data SHALL load into hold and hold_valid SHALL stay 1.
- Otherwise hold_valid SHALL clear.
REQ-023 In RUN, if hold_valid=0, adc_valid=1 and fifo_afull=0, the block SHALL write adc_data directly.
REQ-024 In RUN, if adc_valid=1 and fifo_afull=1:
- hold empty: the sample SHALL go into hold.
- hold full: the sample SHALL be dropped; drop_cnt SHALL increment (saturating) and overflow SHALL be set.
REQ-025 A write SHALL appear as data and wrreq=1 in the cycle after the decision (latency 1); wrreq SHALL be 0 in every other cycle.
REQ-026 Write order SHALL match arrival order: a held sample is always written before any newer sample.
REQ-027 restart=1 in any state SHALL force WAIT_INIT on the next cycle, with the counter at 0.
- restart SHALL clear hold_valid and SHALL NOT issue a write.
- restart SHALL NOT clear drop_cnt or overflow.
REQ-028 If restart=1 in the same cycle as PULSE, restart SHALL win and no rst_proc pulse SHALL be generated.
REQ-029 The block SHALL NOT write while fifo_afull=1, including the cycle in which fifo_afull rises.

Reset
REQ-030 Asserting rst_geral_n=0 SHALL immediately force the following, regardless of clk:
- state=WAIT_INIT, counter=0, hold_valid=0;
- data=0, wrreq=0, rst_proc=0, running=0, drop_cnt=0, overflow=0.
REQ-031 After release, the first counter increment SHALL occur on the first rising clk edge.
REQ-032 Reset in mid-RUN SHALL discard the held sample without writing it.

Structure
REQ-033 A shared package SHALL hold:
- the state enum (WAIT_INIT, PULSE, RUN);
- default constants for DATA_W, INIT_CYCLES and CNT_W, for reuse by the top level and benches.
REQ-034 The one-entry hold register with its write/drop decision SHALL be a sub-module named feeder_skid.
REQ-035 The counter and the state machine SHALL stay in sample_feeder.

Verification
REQ-036 Startup: release reset, INIT_CYCLES=16383, no restart -> rst_proc=1 for exactly one cycle, 16385 cycles after release; running=1 from the next cycle.
REQ-037 Steady flow: fifo_afull=0, adc_valid=1 for 8 cycles with data 1..8 -> wrreq high for 8 consecutive cycles, data 1..8, each one cycle after input; drop_cnt=0.
REQ-038 Backpressure: fifo_afull=1, samples 10, 11, 12 on consecutive cycles -> no wrreq; sample 10 is held; 11 and 12 are dropped; drop_cnt=2; overflow=1. fifo_afull=0 next -> single write of 10.
REQ-039 Simultaneous drain and arrival: hold=20, fifo_afull falls while sample 21 is valid -> 20 is written, 21 is held; next idle cycle -> 21 is written.
REQ-040 Restart mid-RUN: hold=30, assert restart -> 30 is never written; counter restarts; a new rst_proc pulse 16385 cycles later; drop_cnt is unchanged.
REQ-041 Saturation: CNT_W=4, 20 forced drops -> drop_cnt=15 and stays at 15.

Source files
------------

// File: rtl/sample_feeder_pkg.sv
// Shared types and default sizing for the ADC sample feeder.
package sample_feeder_pkg;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    PULSE     = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_INIT_CYCLES = 16383;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/feeder_skid.sv
// One-entry hold register in front of the FIFO: decides write / hold / drop
// each cycle and keeps the saturating drop counter and sticky overflow flag.
module feeder_skid #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              adc_valid_i,
  input  logic              fifo_afull_i,
  output logic [DATA_W-1:0] data_o,
  output logic              wrreq_o,
  output logic [CNT_W-1:0]  drop_cnt_o,
  output logic              overflow_o
);

  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wrreq_q, wrreq_d;
  logic [CNT_W-1:0]  drop_cnt_q;
  logic              overflow_q;
  logic              drop;

  always_comb begin
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    data_d       = data_q;
    wrreq_d      = 1'b0;
    drop         = 1'b0;
    if (flush_i) begin
      hold_valid_d = 1'b0;
    end else if (en_i) begin
      if (!fifo_afull_i) begin
        // Held sample always goes first so arrival order is preserved.
        if (hold_valid_q) begin
          data_d       = hold_data_q;
          wrreq_d      = 1'b1;
          hold_valid_d = adc_valid_i;
          if (adc_valid_i) hold_data_d = adc_data_i;
        end else if (adc_valid_i) begin
          data_d  = adc_data_i;
          wrreq_d = 1'b1;
        end
      end else if (adc_valid_i) begin
        if (hold_valid_q) begin
          drop = 1'b1;
        end else begin
          hold_data_d  = adc_data_i;
          hold_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      data_q       <= '0;
      wrreq_q      <= 1'b0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      data_q       <= data_d;
      wrreq_q      <= wrreq_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  assign data_o     = data_q;
  assign wrreq_o    = wrreq_q;
  assign drop_cnt_o = drop_cnt_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/sample_feeder.sv
// ADC-to-FIFO feeder: waits INIT_CYCLES after reset, pulses rst_proc once,
// then streams samples through a one-entry skid register.
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_geral_n,
  input  logic              restart,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              fifo_afull,
  output logic [DATA_W-1:0] data,
  output logic              wrreq,
  output logic              rst_proc,
  output logic              running,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              overflow
);

  localparam int              CW      = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_END = CW'(INIT_CYCLES);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          rst_proc_q;
  logic          running_q;

  // restart is checked first so it also suppresses a pending PULSE.
  always_ff @(posedge clk or negedge rst_geral_n) begin
    if (!rst_geral_n) begin
      state_q    <= WAIT_INIT;
      cnt_q      <= '0;
      rst_proc_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      rst_proc_q <= 1'b0;
      if (restart) begin
        state_q   <= WAIT_INIT;
        cnt_q     <= '0;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          WAIT_INIT: begin
            if (cnt_q == CNT_END) state_q <= PULSE;
            else                  cnt_q   <= cnt_q + CW'(1);
          end
          PULSE: begin
            state_q    <= RUN;
            rst_proc_q <= 1'b1;
            running_q  <= 1'b1;
          end
          RUN:     state_q <= RUN;
          default: state_q <= WAIT_INIT;
        endcase
      end
    end
  end

  feeder_skid #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_skid (
    .clk          (clk),
    .rst_n        (rst_geral_n),
    .en_i         (running_q),
    .flush_i      (restart),
    .adc_data_i   (adc_data),
    .adc_valid_i  (adc_valid),
    .fifo_afull_i (fifo_afull),
    .data_o       (data),
    .wrreq_o      (wrreq),
    .drop_cnt_o   (drop_cnt),
    .overflow_o   (overflow)
  );

  assign rst_proc = rst_proc_q;
  assign running  = running_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Bench for sample_feeder: queue-based reference model for the default build,
// plus a small build (CNT_W=4, short init) for saturation and restart-vs-pulse.
module tb_sample_feeder;
  import sample_feeder_pkg::*;

  localparam int DW     = DEF_DATA_W;
  localparam int INIT   = DEF_INIT_CYCLES;
  localparam int CW     = DEF_CNT_W;
  localparam int INIT_B = 3;
  localparam int CW_B   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a_n, restart_a, valid_a, afull_a;
  logic [DW-1:0] adc_a, data_a;
  logic          wrreq_a, rp_a, run_a, ovf_a;
  logic [CW-1:0] drop_a;

  logic            rst_b_n, restart_b, valid_b, afull_b;
  logic [DW-1:0]   adc_b, data_b;
  logic            wrreq_b, rp_b, run_b, ovf_b;
  logic [CW_B-1:0] drop_b;

  sample_feeder #(.DATA_W(DW), .INIT_CYCLES(INIT), .CNT_W(CW)) dut_a (
    .clk(clk), .rst_geral_n(rst_a_n), .restart(restart_a),
    .adc_data(adc_a), .adc_valid(valid_a), .fifo_afull(afull_a),
    .data(data_a), .wrreq(wrreq_a), .rst_proc(rp_a), .running(run_a),
    .drop_cnt(drop_a), .overflow(ovf_a)
  );

  sample_feeder #(.DATA_W(DW), .INIT_CYCLES(INIT_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst_geral_n(rst_b_n), .restart(restart_b),
    .adc_data(adc_b), .adc_valid(valid_b), .fifo_afull(afull_b),
    .data(data_b), .wrreq(wrreq_b), .rst_proc(rp_b), .running(run_b),
    .drop_cnt(drop_b), .overflow(ovf_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: cycles since reset/restart decide the mode, a
  // capacity-one queue models the hold slot.
  int            cyc;
  logic [DW-1:0] hq[$];
  logic [DW-1:0] m_data;
  logic          m_wr, m_rp, m_run, m_ovf;
  int            m_drop;

  task automatic model_reset();
    cyc = 0; hq.delete();
    m_data = '0; m_wr = 0; m_rp = 0; m_run = 0; m_ovf = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit was_run;
    m_wr = 0;
    m_rp = 0;
    if (restart_a) begin
      cyc = 0; hq.delete(); m_run = 0;
      return;
    end
    was_run = (cyc >= INIT + 2);
    cyc++;
    m_rp  = (cyc == INIT + 2);
    m_run = (cyc >= INIT + 2);
    if (was_run) begin
      if (!afull_a) begin
        if (hq.size() > 0) begin
          m_data = hq.pop_front(); m_wr = 1;
          if (valid_a) hq.push_back(adc_a);
        end else if (valid_a) begin
          m_data = adc_a; m_wr = 1;
        end
      end else if (valid_a) begin
        if (hq.size() == 0) hq.push_back(adc_a);
        else begin
          m_ovf = 1;
          if (m_drop < (1 << CW) - 1) m_drop++;
        end
      end
    end
  endtask

  task automatic check_a();
    chk("wrreq", wrreq_a, m_wr);
    if (m_wr) chk("data", data_a, m_data);
    chk("rst_proc", rp_a, m_rp);
    chk("running", run_a, m_run);
    chk("drop_cnt", drop_a, m_drop);
    chk("overflow", ovf_a, m_ovf);
  endtask

  task automatic tick_a();
    @(posedge clk);
    model_step();
    #1;
    check_a();
  endtask

  task automatic drive_a(input logic v, input logic [DW-1:0] d, input logic af);
    valid_a = v; adc_a = d; afull_a = af;
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  int saved_drop;

  initial begin
    rst_a_n = 0; restart_a = 0; valid_a = 0; afull_a = 0; adc_a = '0;
    rst_b_n = 0; restart_b = 0; valid_b = 0; afull_b = 0; adc_b = '0;
    model_reset();
    #3;
    check_a();
    chk("data_rst", data_a, 0);

    // startup: single rst_proc pulse INIT+2 edges after release
    @(negedge clk); rst_a_n = 1;
    repeat (INIT + 4) tick_a();

    // steady flow 1..8
    for (int i = 1; i <= 8; i++) begin drive_a(1, DW'(i), 0); tick_a(); end
    drive_a(0, '0, 0); repeat (2) tick_a();
    chk("flow_drop", drop_a, 0);

    // backpressure: 10 held, 11 and 12 dropped
    for (int i = 10; i <= 12; i++) begin drive_a(1, DW'(i), 1); tick_a(); end
    drive_a(0, '0, 0); repeat (3) tick_a();
    chk("bp_drop", drop_a, 2);
    chk("bp_ovf", ovf_a, 1);

    // drain and arrival in the same cycle
    drive_a(1, 16'd20, 1); tick_a();
    drive_a(1, 16'd21, 0); tick_a();
    chk("sim_20", data_a, 20);
    drive_a(0, '0, 0); tick_a();
    chk("sim_21", data_a, 21);
    tick_a();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive_a(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 3) == 0));
      tick_a();
    end
    drive_a(0, '0, 0); repeat (2) tick_a();

    // restart with a held sample
    saved_drop = m_drop;
    drive_a(1, 16'd30, 1); tick_a();
    drive_a(0, '0, 0); restart_a = 1; tick_a();
    restart_a = 0;
    repeat (INIT + 4) tick_a();
    chk("rs_drop", drop_a, saved_drop);

    // asynchronous reset with a held sample
    drive_a(1, 16'd40, 1); tick_a();
    drive_a(0, '0, 0);
    #2; rst_a_n = 0; #1;
    model_reset();
    check_a();
    chk("arst_data", data_a, 0);
    @(negedge clk); rst_a_n = 1;
    repeat (10) tick_a();

    // small build: restart coincident with PULSE suppresses the pulse
    rst_a_n = 0;
    @(negedge clk); rst_b_n = 1;
    for (int k = 1; k <= INIT_B + 1; k++) begin tick_b(); chk("b_rp_pre", rp_b, 0); end
    restart_b = 1; tick_b();
    chk("b_rp_rs", rp_b, 0);
    chk("b_run_rs", run_b, 0);
    restart_b = 0;
    for (int k = 1; k <= INIT_B + 2; k++) begin
      tick_b();
      chk("b_rp", rp_b, (k == INIT_B + 2) ? 1 : 0);
      chk("b_run", run_b, (k == INIT_B + 2) ? 1 : 0);
    end

    // saturation: one sample held, then 20 drops
    afull_b = 1; valid_b = 1;
    for (int k = 1; k <= 21; k++) begin
      adc_b = DW'($urandom);
      tick_b();
      chk("b_sat", drop_b, (k - 1 > 15) ? 15 : k - 1);
      chk("b_ovf", ovf_b, (k >= 2) ? 1 : 0);
      chk("b_wr", wrreq_b, 0);
    end
    valid_b = 0;
    repeat (3) begin tick_b(); chk("b_sat_hold", drop_b, 15); end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
